// File: rtl/sfx_sequencer.sv
// sfx_sequencer: arbitrates jump/score/game-over one-shots and a looping tune into buzzer note indices, one note per tick.
// Optional feature macro: SFX_PREEMPT_EN (equal-or-higher priority effect interrupts the playing one).
module sfx_sequencer #(
    parameter int CLK_HZ  = 50_000_000,
    parameter int NOTE_HZ = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_jump,
    input  logic       req_score,
    input  logic       req_over,
    input  logic       bgm_en,
    output logic [5:0] music_scale,
    output logic       busy,
    output logic [2:0] cur_src
);
    localparam int TICK_DIV = CLK_HZ / NOTE_HZ;
    localparam int CW = $clog2(TICK_DIV);
    typedef enum logic [1:0] {IDLE, BGM, FX} state_t;
    localparam logic [5:0] ROM [4][16] = '{
        '{6'd8, 6'd8, 6'd12, 6'd12, 6'd13, 6'd13, 6'd12, 6'd0,
          6'd11, 6'd11, 6'd10, 6'd10, 6'd9, 6'd9, 6'd8, 6'd0},
        '{6'd8, 6'd12, 6'd15, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0,
          6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0},
        '{6'd15, 6'd17, 6'd19, 6'd15, 6'd0, 6'd0, 6'd0, 6'd0,
          6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0},
        '{6'd12, 6'd11, 6'd10, 6'd9, 6'd8, 6'd7, 6'd6, 6'd1,
          6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0}
    };
    state_t        st_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    pend_q, pend_d, clr;
    logic [3:0]    step_q, pos_q, len;
    logic [1:0]    psel, ssel;
    logic          tick, start, preempt;
    logic [5:0]    ms_q;
    logic          busy_q;
    logic [2:0]    src_q;
    // Tick timing, arbitration and the start decision; ROM rows: 0 bgm, 1 jump, 2 score, 3 over.
    always_comb begin
        tick = cnt_q == CW'(TICK_DIV - 1);
        cnt_d = tick ? '0 : cnt_q + 1'b1;
        psel = pend_q[2] ? 2'd3 : pend_q[1] ? 2'd2 : 2'd1;
        ssel = src_q == 3'd4 ? 2'd3 : src_q == 3'd3 ? 2'd2 : src_q == 3'd2 ? 2'd1 : 2'd0;
        len = ssel == 2'd1 ? 4'd3 : ssel == 2'd2 ? 4'd4 : 4'd8;
`ifdef SFX_PREEMPT_EN
        preempt = psel >= ssel;
`else
        preempt = 1'b0;
`endif
        start = |pend_q && (st_q != FX || step_q == len || preempt);
        clr = {psel == 2'd3, psel == 2'd2, psel == 2'd1} & {3{tick && start}};
        pend_d = (pend_q & ~clr) | {req_over, req_score, req_jump};
    end
    // Free-running note tick counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else cnt_q <= cnt_d;
    end
    // Sequencer FSM: pending requests every cycle, state and registered outputs only on tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q <= IDLE;
            pend_q <= '0;
            step_q <= '0;
            pos_q <= '0;
            ms_q <= '0;
            busy_q <= 1'b0;
            src_q <= '0;
        end else begin
            pend_q <= pend_d;
            if (tick) begin
                if (start) begin
                    st_q <= FX;
                    src_q <= {1'b0, psel} + 3'd1;
                    step_q <= 4'd1;
                    ms_q <= ROM[psel][4'd0];
                    busy_q <= 1'b1;
                end else if (st_q == FX && step_q < len) begin
                    ms_q <= ROM[ssel][step_q];
                    step_q <= step_q + 1'b1;
                end else if (bgm_en) begin
                    st_q <= BGM;
                    src_q <= 3'd1;
                    step_q <= '0;
                    ms_q <= ROM[2'd0][pos_q];
                    pos_q <= pos_q + 1'b1;
                    busy_q <= 1'b0;
                end else begin
                    st_q <= IDLE;
                    src_q <= '0;
                    step_q <= '0;
                    ms_q <= '0;
                    busy_q <= 1'b0;
                    if (st_q == BGM) pos_q <= '0;
                end
            end
        end
    end
    assign music_scale = ms_q;
    assign busy = busy_q;
    assign cur_src = src_q;
endmodule

// File: tb/tb_sfx_sequencer.sv
// tb_sfx_sequencer: table-driven per-tick vectors with a scoreboard queue for sfx_sequencer at TICK_DIV = 10.
module tb_sfx_sequencer;
    typedef struct {
        bit         r, j, s, o, b;
        logic [5:0] ms;
        logic       bz;
        logic [2:0] src;
    } vec_t;
    typedef struct {
        logic [5:0] ms;
        logic       bz;
        logic [2:0] src;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    exp_t prev;
    exp_t z;
    int errors = 0;
    int checks = 0;

    logic clk = 1'b0, rst_n = 1'b0;
    logic req_jump = 1'b0, req_score = 1'b0, req_over = 1'b0, bgm_en = 1'b0;
    logic [5:0] music_scale;
    logic busy;
    logic [2:0] cur_src;

    always #5 clk = ~clk;

    sfx_sequencer #(.CLK_HZ(40), .NOTE_HZ(4)) dut (
        .clk(clk), .rst_n(rst_n), .req_jump(req_jump), .req_score(req_score),
        .req_over(req_over), .bgm_en(bgm_en), .music_scale(music_scale),
        .busy(busy), .cur_src(cur_src)
    );

    task automatic cmp(input string name, input exp_t e);
        checks++;
        if ({music_scale, busy, cur_src} !== {e.ms, e.bz, e.src}) begin
            errors++;
            $display("FAIL %s @%0t: got ms=%0d busy=%0d src=%0d, want ms=%0d busy=%0d src=%0d",
                     name, $time, music_scale, busy, cur_src, e.ms, e.bz, e.src);
        end
    endtask

    task automatic add(input bit r, input bit j, input bit s, input bit o, input bit b,
                       input int ms, input bit bz, input int src);
        vec_t v;
        v.r = r; v.j = j; v.s = s; v.o = o; v.b = b;
        v.ms = 6'(ms); v.bz = bz; v.src = 3'(src);
        vecs.push_back(v);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        {req_jump, req_score, req_over, bgm_en} = '0;
        #1 cmp("reset", z);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        prev = z;
    endtask

    // One tick period: hold check mid-period, optional one-cycle request, scoreboard check after the tick edge.
    task automatic step(input bit j, input bit s, input bit o, input bit b, input exp_t e);
        exp_t got;
        sb.push_back(e);
        bgm_en = b;
        repeat (3) @(posedge clk);
        #1 cmp("hold", prev);
        @(negedge clk);
        req_jump = j; req_score = s; req_over = o;
        @(posedge clk);
        #1 {req_jump, req_score, req_over} = '0;
        repeat (6) @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL scoreboard: queue empty, want 1 entry");
        end else begin
            got = sb.pop_front();
            cmp("tick", got);
            prev = got;
        end
    endtask

    initial begin
        exp_t e;
        z = '{6'd0, 1'b0, 3'd0};
        prev = z;
        for (int i = 0; i < 5; i++) add(i == 0, 0, 0, 0, 0, 0, 0, 0);
        add(1, 1, 0, 0, 0, 8, 1, 2);
        add(0, 0, 0, 0, 0, 12, 1, 2);
        add(0, 0, 0, 0, 0, 15, 1, 2);
        add(0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0);
        add(1, 0, 0, 0, 1, 8, 0, 1);
        add(0, 0, 0, 0, 1, 8, 0, 1);
        add(0, 0, 0, 0, 1, 12, 0, 1);
        add(0, 0, 1, 0, 1, 15, 1, 3);
        add(0, 0, 0, 0, 1, 17, 1, 3);
        add(0, 0, 0, 0, 1, 19, 1, 3);
        add(0, 0, 0, 0, 1, 15, 1, 3);
        add(0, 0, 0, 0, 1, 12, 0, 1);
        add(0, 0, 0, 0, 1, 13, 0, 1);
        add(0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 1, 8, 0, 1);
        add(1, 1, 0, 1, 0, 12, 1, 4);
        add(0, 0, 0, 0, 0, 11, 1, 4);
        add(0, 0, 0, 0, 0, 10, 1, 4);
        add(0, 0, 0, 0, 0, 9, 1, 4);
        add(0, 0, 0, 0, 0, 8, 1, 4);
        add(0, 0, 0, 0, 0, 7, 1, 4);
        add(0, 0, 0, 0, 0, 6, 1, 4);
        add(0, 0, 0, 0, 0, 1, 1, 4);
        add(0, 0, 0, 0, 0, 8, 1, 2);
        add(0, 0, 0, 0, 0, 12, 1, 2);
        add(0, 0, 0, 0, 0, 15, 1, 2);
        add(0, 0, 0, 0, 0, 0, 0, 0);
        add(1, 1, 0, 0, 0, 8, 1, 2);
        add(0, 0, 0, 0, 0, 12, 1, 2);
`ifdef SFX_PREEMPT_EN
        add(0, 0, 0, 1, 0, 12, 1, 4);
`else
        add(0, 0, 0, 1, 0, 15, 1, 2);
        add(0, 0, 0, 0, 0, 12, 1, 4);
`endif
        add(0, 0, 0, 0, 0, 11, 1, 4);
        add(0, 0, 0, 0, 0, 10, 1, 4);
        add(0, 0, 0, 0, 0, 9, 1, 4);
        add(0, 0, 0, 0, 0, 8, 1, 4);
        add(0, 0, 0, 0, 0, 7, 1, 4);
        add(0, 0, 0, 0, 0, 6, 1, 4);
        add(0, 0, 0, 0, 0, 1, 1, 4);
        add(0, 0, 0, 0, 0, 0, 0, 0);
        add(1, 1, 0, 0, 0, 8, 1, 2);
`ifdef SFX_PREEMPT_EN
        add(0, 1, 0, 0, 0, 8, 1, 2);
`else
        add(0, 1, 0, 0, 0, 12, 1, 2);
        add(0, 0, 0, 0, 0, 15, 1, 2);
        add(0, 0, 0, 0, 0, 8, 1, 2);
`endif
        add(0, 0, 0, 0, 0, 12, 1, 2);
        add(0, 0, 0, 0, 0, 15, 1, 2);
        add(0, 0, 0, 0, 0, 0, 0, 0);

        foreach (vecs[i]) begin
            if (vecs[i].r) do_reset();
            e = '{vecs[i].ms, vecs[i].bz, vecs[i].src};
            step(vecs[i].j, vecs[i].s, vecs[i].o, vecs[i].b, e);
        end

        do_reset();
        step(0, 0, 1, 0, '{6'd12, 1'b1, 3'd4});
        step(0, 0, 0, 0, '{6'd11, 1'b1, 3'd4});
        repeat (3) @(posedge clk);
        @(negedge clk) req_score = 1'b1;
        @(posedge clk);
        #1 req_score = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        #1 cmp("async_reset", z);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        prev = z;
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, z);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
